// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes, funct3 sizes, LSU state.
// Used by lsu_ctrl and lsu_align.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  // Undefined funct3 encodings behave as word accesses
  function automatic lsu_size_t f3_size(
    input logic [2:0] f3
  );
    lsu_size_t s;
    s = SZ_W;
    if (f3 == F3_B || f3 == F3_BU) s = SZ_B;
    if (f3 == F3_H || f3 == F3_HU) s = SZ_H;
    return s;
  endfunction

  function automatic logic f3_signed(
    input logic [2:0] f3
  );
    return (f3 == F3_B) || (f3 == F3_H);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store byte enables and replication,
// load lane select with sign/zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata_rep,
  output logic [31:0] o_rdata_ext
);

  lsu_size_t   w_size;
  logic        w_sgn;
  logic [31:0] w_shift;

  assign w_size  = f3_size(i_funct3);
  assign w_sgn   = f3_signed(i_funct3);
  assign w_shift = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_be        = 4'b1111;
    o_wdata_rep = i_wdata;
    o_rdata_ext = w_shift;
    unique case (w_size)
      SZ_B: begin
        o_be        = 4'b0001 << i_offset;
        o_wdata_rep = {4{i_wdata[7:0]}};
        o_rdata_ext = {{24{w_sgn & w_shift[7]}},
                       w_shift[7:0]};
      end
      SZ_H: begin
        o_be        = 4'b0011 << i_offset;
        o_wdata_rep = {2{i_wdata[15:0]}};
        o_rdata_ext = {{16{w_sgn & w_shift[15]}},
                       w_shift[15:0]};
      end
      default: begin
        o_be        = 4'b1111;
        o_wdata_rep = i_wdata;
        o_rdata_ext = w_shift;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: IDLE/REQ/WAIT/DONE with timeout.
// Define LSU_MISALIGN_TRAP_EN to fault on misaligned H/W accesses.
module lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_flag,
  input  logic        store_flag,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        fault
);

  localparam int CLG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW  = (CLG > 8) ? CLG : 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_f3;
  logic        r_store;
  logic        r_fault;
  logic        r_ok;
  logic [31:0] r_wb_data;

  logic        w_one;
  logic        w_both;
  logic [1:0]  w_off;
  logic        w_trap;
  logic        w_tmo;
  logic        w_latch;
  logic        w_fault_set;
  logic        w_ok_set;
  logic        w_cap;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_rdata_ext;

  assign w_one  = load_flag ^ store_flag;
  assign w_both = load_flag & store_flag;
  assign w_tmo  = (r_cnt >= TO_LAST);

  // Offending low bits are cleared so lanes stay inside the word
  always_comb begin
    w_off = 2'b00;
    unique case (f3_size(funct3))
      SZ_B:    w_off = addr[1:0];
      SZ_H:    w_off = {addr[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = (w_off != addr[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  lsu_align u_align (
    .i_funct3    (r_f3),
    .i_offset    (r_addr[1:0]),
    .i_wdata     (r_wdata),
    .i_rdata     (mem_rdata),
    .o_be        (w_be),
    .o_wdata_rep (w_wdata_rep),
    .o_rdata_ext (w_rdata_ext)
  );

  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_fault_set = 1'b0;
    w_ok_set    = 1'b0;
    w_cap       = 1'b0;
    stall       = 1'b0;
    mem_req     = 1'b0;
    unique case (r_state)
      IDLE: begin
        stall = load_flag | store_flag;
        if (w_both || (w_one && w_trap)) begin
          w_fault_set = 1'b1;
          w_next      = DONE;
        end else if (w_one) begin
          w_latch = 1'b1;
          w_next  = REQ;
        end
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt && r_store) begin
          w_next = DONE;
        end else if (w_tmo) begin
          w_fault_set = 1'b1;
          w_next      = DONE;
        end else if (mem_gnt) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          w_cap    = 1'b1;
          w_ok_set = 1'b1;
          w_next   = DONE;
        end else if (w_tmo) begin
          w_fault_set = 1'b1;
          w_next      = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign mem_we    = mem_req & r_store;
  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_be    = mem_req ? w_be : 4'b0000;
  assign mem_wdata = mem_req ? w_wdata_rep : 32'h0;
  assign wb_valid  = r_ok;
  assign wb_data   = r_wb_data;
  assign fault     = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_f3      <= '0;
      r_store   <= 1'b0;
      r_fault   <= 1'b0;
      r_ok      <= 1'b0;
      r_wb_data <= '0;
    end else begin
      r_state <= w_next;
      r_fault <= w_fault_set;
      r_ok    <= w_ok_set;
      if (w_latch) begin
        r_addr  <= {addr[31:2], w_off};
        r_wdata <= wdata;
        r_f3    <= funct3;
        r_store <= store_flag;
        r_cnt   <= '0;
      end else if (r_state == REQ || r_state == WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_cap) r_wb_data <= w_rdata_ext;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: vector table, random
// transactions against a transaction-level model, reset cases.
module tb_lsu_ctrl;

  localparam int TO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_flag = 1'b0;
  logic        store_flag = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        fault;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_flag  (load_flag),
    .store_flag (store_flag),
    .addr       (addr),
    .wdata      (wdata),
    .funct3     (funct3),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;
    int          rd;
  } txn_t;

  typedef struct {
    int          stall_n;
    int          req_n;
    int          fault_n;
    int          wb_n;
    int          unstable;
    logic [31:0] wb_data;
    logic [31:0] be;
    logic [31:0] mwd;
    logic [31:0] maddr;
    logic [31:0] we;
  } res_t;

  typedef struct {
    txn_t t;
    res_t e;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic res_t blank();
    res_t r;
    r.stall_n = 0; r.req_n = 0; r.fault_n = 0; r.wb_n = 0;
    r.unstable = 0; r.wb_data = '0; r.be = '0; r.mwd = '0;
    r.maddr = '0; r.we = '0;
    return r;
  endfunction

  // Transaction-level reference derived from the access rules
  function automatic res_t model(input txn_t t);
    res_t e;
    int sz, off, g, total;
    bit sgn, mis, ok;
    logic [31:0] lane;
    e = blank();
    sz = (t.f3 == 0 || t.f3 == 4) ? 1 :
         (t.f3 == 1 || t.f3 == 5) ? 2 : 4;
    sgn = (t.f3 == 0 || t.f3 == 1);
    off = int'(t.addr % 4);
    off = off - (off % sz);
    mis = (int'(t.addr % 4) != off);
    if ((t.ld && t.st) || (mis && TRAP_EN)) begin
      e.stall_n = 1;
      e.fault_n = 1;
      return e;
    end
    g = t.gd + 1;
    total = t.st ? g : g + t.rd + 1;
    ok = (total <= TO);
    e.stall_n = 1 + ((total < TO) ? total : TO);
    e.req_n = (g < TO) ? g : TO;
    e.fault_n = ok ? 0 : 1;
    e.maddr = t.addr & ~32'd3;
    e.we = t.st ? 1 : 0;
    e.be = ((32'd1 << sz) - 1) << off;
    e.mwd = (sz == 1) ? t.wdata[7:0] * 32'h01010101 :
            (sz == 2) ? t.wdata[15:0] * 32'h00010001 : t.wdata;
    if (ok && t.ld) begin
      e.wb_n = 1;
      lane = t.rdata >> (8 * off);
      if (sz == 1) begin
        lane = lane % 256;
        if (sgn && lane >= 128) lane = lane + 32'hFFFFFF00;
      end else if (sz == 2) begin
        lane = lane % 65536;
        if (sgn && lane >= 32768) lane = lane + 32'hFFFF0000;
      end
      e.wb_data = lane;
    end
    return e;
  endfunction

  task automatic run(input txn_t t, input bit noise, output res_t r);
    bit waiting, seen_done;
    int ridx, widx, tail;
    logic [31:0] a0, w0;
    logic [3:0] b0;
    logic we0;
    r = blank();
    waiting = 0; seen_done = 0;
    ridx = 0; widx = 0; tail = 0;
    a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      load_flag  = (k == 0) ? t.ld : 1'b0;
      store_flag = (k == 0) ? t.st : 1'b0;
      addr   = (k == 0) ? t.addr : $urandom;
      wdata  = (k == 0) ? t.wdata : $urandom;
      funct3 = (k == 0) ? t.f3 : 3'($urandom);
      if (waiting) begin
        mem_rvalid = (widx == t.rd);
        widx++;
      end else begin
        mem_rvalid = noise ? 1'($urandom % 2) : 1'b0;
      end
      mem_rdata = mem_rvalid ? t.rdata : $urandom;
      mem_gnt = 1'b0;
      if (mem_req) begin
        mem_gnt = (ridx == t.gd);
        if (mem_gnt && t.ld) waiting = 1;
        ridx++;
      end
      #1;
      if (stall) r.stall_n++;
      if (mem_req) begin
        r.req_n++;
        if (r.req_n == 1) begin
          a0 = mem_addr; w0 = mem_wdata; b0 = mem_be; we0 = mem_we;
        end else if (a0 !== mem_addr || w0 !== mem_wdata ||
                     b0 !== mem_be || we0 !== mem_we) begin
          r.unstable = 1;
        end
      end
      if (fault) r.fault_n++;
      if (wb_valid) begin
        r.wb_n++;
        r.wb_data = wb_data;
      end
      if (k > 0 && !stall && !seen_done) begin
        seen_done = 1;
        tail = k + 1;
      end
      if (seen_done && k >= tail) break;
    end
    chk("done_reached", 32'(seen_done), 32'd1);
    load_flag = 0; store_flag = 0; mem_gnt = 0; mem_rvalid = 0;
    r.maddr = a0; r.mwd = w0; r.be = 32'(b0); r.we = 32'(we0);
  endtask

  task automatic compare(input string tag, input txn_t t,
                         input res_t e, input res_t r);
    chk({tag, ".stall_cycles"}, r.stall_n, e.stall_n);
    chk({tag, ".req_cycles"}, r.req_n, e.req_n);
    chk({tag, ".fault_pulses"}, r.fault_n, e.fault_n);
    chk({tag, ".wb_valid_cycles"}, r.wb_n, e.wb_n);
    if (e.wb_n > 0) chk({tag, ".wb_data"}, r.wb_data, e.wb_data);
    if (e.req_n > 0) begin
      chk({tag, ".mem_addr"}, r.maddr, e.maddr);
      chk({tag, ".mem_we"}, r.we, e.we);
      chk({tag, ".req_stable"}, r.unstable, 0);
      if (t.st) begin
        chk({tag, ".mem_be"}, r.be, e.be);
        chk({tag, ".mem_wdata"}, r.mwd, e.mwd);
      end
    end
  endtask

  function automatic void add(
    input logic ld, input logic st, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] rdv, input int gd, input int rd,
    input int sn, input int rn, input int fn, input int wn,
    input logic [31:0] wbd, input logic [31:0] be,
    input logic [31:0] mwd, input logic [31:0] ma);
    vec_t v;
    v.t.ld = ld; v.t.st = st; v.t.f3 = f3; v.t.addr = a;
    v.t.wdata = wd; v.t.rdata = rdv; v.t.gd = gd; v.t.rd = rd;
    v.e = blank();
    v.e.stall_n = sn; v.e.req_n = rn; v.e.fault_n = fn;
    v.e.wb_n = wn; v.e.wb_data = wbd; v.e.be = be;
    v.e.mwd = mwd; v.e.maddr = ma; v.e.we = st ? 1 : 0;
    tbl.push_back(v);
  endfunction

  initial begin
    txn_t t;
    res_t r;
    add(0,1,2,32'h100,32'hDEADBEEF,0,0,0, 2,1,0,0,0,4'hF,32'hDEADBEEF,32'h100);
    add(1,0,0,32'h103,0,32'h80000000,0,0, 3,1,0,1,32'hFFFFFF80,0,0,32'h100);
    add(1,0,4,32'h103,0,32'h80000000,0,0, 3,1,0,1,32'h00000080,0,0,32'h100);
    add(0,1,1,32'h102,32'h1234,0,0,0, 2,1,0,0,0,4'hC,32'h12341234,32'h100);
    if (TRAP_EN)
      add(1,0,2,32'h101,0,32'hCAFEF00D,0,0, 1,0,1,0,0,0,0,0);
    else
      add(1,0,2,32'h101,0,32'hCAFEF00D,0,0, 3,1,0,1,32'hCAFEF00D,0,0,32'h100);
    add(1,0,2,32'h200,0,32'h1,9,0, 5,4,1,0,0,0,0,32'h200);
    add(1,1,2,32'h300,0,0,0,0, 1,0,1,0,0,0,0,0);
    add(0,1,0,32'h101,32'h123456A5,0,0,0, 2,1,0,0,0,4'h2,32'hA5A5A5A5,32'h100);
    add(1,0,1,32'h102,0,32'h80010000,0,0, 3,1,0,1,32'hFFFF8001,0,0,32'h100);
    add(1,0,5,32'h102,0,32'h80010000,0,0, 3,1,0,1,32'h00008001,0,0,32'h100);
    add(0,1,2,32'h104,32'h1,0,2,0, 4,3,0,0,0,4'hF,32'h1,32'h104);
    add(1,0,2,32'h108,0,32'h55AA55AA,1,1, 5,2,0,1,32'h55AA55AA,0,0,32'h108);
    add(1,0,2,32'h108,0,32'h55AA55AA,1,2, 5,2,1,0,0,0,0,32'h108);
    add(0,1,3,32'h10C,32'h87654321,0,0,0, 2,1,0,0,0,4'hF,32'h87654321,32'h10C);
    if (TRAP_EN)
      add(0,1,1,32'h103,32'hBEEF,0,0,0, 1,0,1,0,0,0,0,0);
    else
      add(0,1,1,32'h103,32'hBEEF,0,0,0, 2,1,0,0,0,4'hC,32'hBEEFBEEF,32'h100);
    add(0,1,2,32'h110,32'h5,0,3,0, 5,4,0,0,0,4'hF,32'h5,32'h110);
    add(1,0,2,32'h114,0,32'h7,3,0, 5,4,1,0,0,0,0,32'h114);

    repeat (2) @(negedge clk);
    chk("rst.stall", 32'(stall), 0);
    chk("rst.mem_req", 32'(mem_req), 0);
    chk("rst.mem_we", 32'(mem_we), 0);
    chk("rst.wb_valid", 32'(wb_valid), 0);
    chk("rst.fault", 32'(fault), 0);
    chk("rst.wb_data", wb_data, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_be", 32'(mem_be), 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      run(tbl[i].t, 1'b1, r);
      compare($sformatf("vec%0d", i), tbl[i].t, tbl[i].e, r);
    end

    // Reset while waiting for read data abandons the access
    @(negedge clk);
    load_flag = 1; addr = 32'h100; funct3 = 3'd2;
    @(negedge clk);
    load_flag = 0; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    #1 chk("midrst.wait_stall", 32'(stall), 1);
    #2 rst_n = 1'b0;
    #1 chk("midrst.stall_now", 32'(stall), 0);
    chk("midrst.req_now", 32'(mem_req), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("midrst.stall%0d", c), 32'(stall), 0);
      chk($sformatf("midrst.wb_valid%0d", c), 32'(wb_valid), 0);
      chk($sformatf("midrst.fault%0d", c), 32'(fault), 0);
      @(negedge clk);
      mem_rvalid = 0;
    end

    for (int i = 0; i < 200; i++) begin
      int sel;
      sel = int'($urandom % 10);
      t.ld = (sel == 0) || (sel < 5);
      t.st = (sel == 0) || (sel >= 5);
      t.f3 = 3'($urandom % 8);
      t.addr = $urandom;
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.gd = int'($urandom % 6);
      t.rd = int'($urandom % 4);
      run(t, 1'b1, r);
      compare($sformatf("rnd%0d", i), t, model(t), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum cycles spent in REQ plus WAIT before abort.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 load_flag  input  1  SHALL request a load (from ALU decode).
REQ-005 store_flag  input  1  SHALL request a store.
REQ-006 addr  input  32  SHALL carry the effective byte address (rs1+imm).
REQ-007 wdata  input  32  SHALL carry rs2 store data.
REQ-008 funct3  input  3  SHALL encode size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU; others treated as W.
REQ-009 mem_req, mem_we  output  1 each  SHALL form the memory request and write-enable.
REQ-010 mem_addr  output  32  SHALL be the word-aligned address {addr[31:2],2'b00}.
REQ-011 mem_wdata  output  32, mem_be  output  4  SHALL be lane-replicated store data and byte enables.
REQ-012 mem_gnt, mem_rvalid  input  1 each; mem_rdata  input  32  SHALL form the memory response.
REQ-013 stall  output  1  SHALL freeze PC/pipeline while an access is outstanding.
REQ-014 wb_valid  output  1; wb_data  output  32  SHALL deliver load writeback.
REQ-015 fault  output  1  SHALL pulse one cycle on a misaligned access, timeout, or dual request.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-017 IDLE: exactly one flag high -> latch addr, wdata, funct3, direction; go REQ; stall high combinationally that same cycle.
REQ-018 IDLE: both flags high -> no memory access, fault pulse, go DONE.
REQ-019 REQ: mem_req=1, outputs driven from latched values, stable until mem_gnt; on gnt a store goes DONE, a load goes WAIT.
REQ-020 WAIT: mem_req=0; on mem_rvalid capture extracted data into wb_data, go DONE; mem_rvalid outside WAIT ignored.
REQ-021 DONE: stall=0, wb_valid=1 for one cycle on a successful load only; flags ignored; next state IDLE.
REQ-022 stall SHALL be high in REQ, in WAIT, and in IDLE while a flag is asserted.
REQ-023 Byte enables: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<addr[1:0]; W 4'b1111; mem_be=0 for loads is not required.
REQ-024 Store data SHALL be replicated: byte x4, half x2, word as-is.
REQ-025 Load extraction SHALL select the lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend.
REQ-026 Timeout counter (8+ bits) SHALL clear on IDLE->REQ, increment each REQ/WAIT cycle; reaching TIMEOUT_CYCLES -> fault pulse, mem_req dropped, go DONE, wb_valid=0.
REQ-027 Minimum latency: store with immediate gnt = 2 stall cycles; load with gnt and rvalid next cycle = 3 stall cycles.

Reset
REQ-028 Reset SHALL force IDLE, counter 0, latched fields 0, and all outputs 0 (stall, mem_req, mem_we, wb_valid, fault, wb_data, mem_addr, mem_be, mem_wdata).
REQ-029 Reset asserted mid-access SHALL abandon the access immediately; no fault, no wb_valid after release.

Configuration
REQ-030 With LSU_MISALIGN_TRAP_EN defined, H with addr[0]=1 or W with addr[1:0]!=0 SHALL skip memory, pulse fault, go IDLE->DONE.
REQ-031 Without LSU_MISALIGN_TRAP_EN, misaligned access SHALL proceed with offending low address bits forced to zero; fault never asserted for misalignment.

Structure
REQ-032 Shared package riscv_pkg SHALL hold LOAD/STORE opcode constants, funct3 size constants and the lsu_state_t enum.
REQ-033 Lane shift/replicate/extend logic SHALL reside in combinational sub-module lsu_align, instantiated once.

Verification
REQ-034 SW addr=0x100, wdata=0xDEADBEEF, gnt on first REQ cycle -> mem_addr=0x100, mem_be=4'hF, mem_we=1, stall 2 cycles, no wb_valid.
REQ-035 LB addr=0x103, mem_rdata=0x80000000 -> wb_data=0xFFFFFF80, wb_valid 1 cycle; LBU same -> 0x00000080.
REQ-036 SH addr=0x102, wdata=0x1234 -> mem_be=4'b1100, mem_wdata=0x12341234.
REQ-037 LW addr=0x101: with macro -> fault pulse, mem_req never high; without -> mem_addr=0x100, no fault.
REQ-038 Load with gnt withheld, TIMEOUT_CYCLES=4 -> fault after 4 REQ cycles, DONE, wb_valid=0, then IDLE.
REQ-039 rst_n low during WAIT, rvalid after release -> stays IDLE, stall=0, wb_valid=0.
